run_match_monitor: RTL and testbench

//  Parametrised successor of the basic toggle/run-counter property block for the SoCV benches.

---
 rtl/run_mon_pkg.sv | 13 +
 rtl/run_ref_pattern.sv | 40 ++++
 rtl/run_match_monitor.sv | 85 ++++++++
 tb/tb_run_match_monitor.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/run_mon_pkg.sv
// run_mon_pkg: shared FSM state encoding and counter-range helper for run_match_monitor.
package run_mon_pkg;
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_e;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/run_ref_pattern.sv
// run_ref_pattern: W-bit reference that inverts every PERIOD enabled cycles, plus a one-cycle delayed copy.
module run_ref_pattern #(
    parameter int W      = 1,
    parameter int PERIOD = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] exp_o,
    output logic [W-1:0] exp_dly_o
);
    localparam int PH_W = PERIOD > 1 ? $clog2(PERIOD) : 1;

    logic [PH_W-1:0] ph_q, ph_d;
    logic [W-1:0]    exp_q, exp_d, dly_q, dly_d;
    logic            ph_last;

    assign ph_last = ph_q == PH_W'(PERIOD - 1);

    always_comb begin
        ph_d  = en_i ? (ph_last ? '0 : PH_W'(ph_q + 1'b1)) : ph_q;
        exp_d = en_i && ph_last ? ~exp_q : exp_q;
        dly_d = en_i ? exp_q : dly_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_q  <= '0;
            exp_q <= '0;
            dly_q <= '0;
        end else begin
            ph_q  <= ph_d;
            exp_q <= exp_d;
            dly_q <= dly_d;
        end
    end

    assign exp_o     = exp_q;
    assign exp_dly_o = dly_q;
endmodule

// File: rtl/run_match_monitor.sv
// run_match_monitor: counts consecutive cycles where i matches a toggling reference,
// tracks lock/loss in a 4-state FSM and exposes property flags.
module run_match_monitor
    import run_mon_pkg::*;
#(
    parameter int W      = 1,
    parameter int CNT_W  = 3,
    parameter int THRESH = 5,
    parameter int PERIOD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             sat_mode,
    input  logic [W-1:0]     i,
    output logic [CNT_W-1:0] run_cnt,
    output logic [1:0]       state,
    output logic             lost,
    output logic             z_idle,
    output logic             hit_hi,
    output logic             hit_lo,
    output logic             echo
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

    if (THRESH < 1 || THRESH > cnt_max(CNT_W) || PERIOD < 1) begin : g_param_check
        $fatal(1, "run_match_monitor: THRESH or PERIOD out of range");
    end

    logic [W-1:0]     exp, exp_dly, prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    state_e           state_q, state_d;
    logic             match;

    run_ref_pattern #(.W(W), .PERIOD(PERIOD)) u_ref (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en),
        .exp_o     (exp),
        .exp_dly_o (exp_dly)
    );

    assign match   = i == exp;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        prev_d  = en ? i : prev_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (clr) begin
            cnt_d   = '0;
            state_d = SEARCH;
        end else if (en) begin
            cnt_d = !match ? '0 : cnt_q == MAX ? (sat_mode ? cnt_q : '0) : cnt_inc;
            case (state_q)
                SEARCH:  state_d = match ? (THRESH == 1 ? LOCKED : TRACK) : SEARCH;
                TRACK:   state_d = !match ? SEARCH : cnt_inc == THR ? LOCKED : TRACK;
                LOCKED:  state_d = match ? LOCKED : LOST;
                default: state_d = LOST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q  <= '0;
            cnt_q   <= '0;
            state_q <= SEARCH;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign run_cnt = cnt_q;
    assign state   = state_q;
    assign lost    = state_q == LOST;
    assign z_idle  = exp == '0 && exp_dly == '0 && i == '0;
    assign hit_hi  = cnt_q == THR && exp[0];
    assign hit_lo  = cnt_q == THR && !exp[0];
    assign echo    = cnt_q != '0 && prev_q == exp;
endmodule

// File: tb/tb_run_match_monitor.sv
// tb_run_match_monitor: directed checks of two monitor instances (default params, and W=4 PERIOD=3).
module tb_run_match_monitor;
    logic       clk, rst_n, en, clr, sat_mode;
    logic       i1;
    logic [3:0] i4;
    logic [2:0] cnt1, cnt4;
    logic [1:0] st1, st4;
    logic       lost1, z1, hh1, hl1, ec1;
    logic       lost4, z4, hh4, hl4, ec4;
    int         n_cmp, n_bad;
    logic       e1;
    logic [3:0] e4, d4;
    int         ph4;

    run_match_monitor dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sat_mode(sat_mode), .i(i1),
        .run_cnt(cnt1), .state(st1), .lost(lost1), .z_idle(z1),
        .hit_hi(hh1), .hit_lo(hl1), .echo(ec1)
    );

    run_match_monitor #(.W(4), .CNT_W(3), .THRESH(5), .PERIOD(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sat_mode(sat_mode), .i(i4),
        .run_cnt(cnt4), .state(st4), .lost(lost4), .z_idle(z4),
        .hit_hi(hh4), .hit_lo(hl4), .echo(ec4)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 0; clr = 0; en = 1; i1 = 0; i4 = 0;
        @(posedge clk); #1;
        rst_n = 1; e1 = 0; e4 = 0; d4 = 0; ph4 = 0;
    endtask

    // e1 tracks the expected reference of dut1 (inverts every enabled edge)
    task automatic step1(input logic iv);
        i1 = iv;
        @(posedge clk); #1;
        if (en) e1 = ~e1;
    endtask

    task automatic step4(input logic [3:0] iv);
        i4 = iv;
        @(posedge clk); #1;
        if (en) begin
            d4 = e4;
            if (ph4 == 2) begin ph4 = 0; e4 = ~e4; end else ph4++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (cnt1 !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt1); end
        n_cmp++; if (st1 !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st1); end
        n_cmp++; if ({lost1, hh1, hl1, ec1} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {lost1, hh1, hl1, ec1}); end
        n_cmp++; if (z1 !== 1'b1) begin n_bad++; $display("FAIL reset_zidle0: got %b want 1", z1); end
        i1 = 1; #1;
        n_cmp++; if (z1 !== 1'b0) begin n_bad++; $display("FAIL reset_zidle1: got %b want 0", z1); end
        i1 = 0;
    endtask

    task automatic test_lock();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step1(e1);
            n_cmp++; if (cnt1 !== 3'(k)) begin n_bad++; $display("FAIL lock_cnt%0d: got %0d want %0d", k, cnt1, k); end
            n_cmp++; if (st1 !== (k < 5 ? 2'd1 : 2'd2)) begin n_bad++; $display("FAIL lock_state%0d: got %0d want %0d", k, st1, k < 5 ? 1 : 2); end
        end
        n_cmp++; if ({hh1, hl1, ec1} !== 3'b100) begin n_bad++; $display("FAIL lock_hit: got hh/hl/echo=%b want 100", {hh1, hl1, ec1}); end
    endtask

    task automatic test_loss();
        step1(~e1);
        n_cmp++; if ({st1, lost1, cnt1} !== {2'd3, 1'b1, 3'd0}) begin n_bad++; $display("FAIL loss_enter: got st=%0d lost=%b cnt=%0d want 3 1 0", st1, lost1, cnt1); end
        step1(e1);
        n_cmp++; if ({st1, lost1, cnt1} !== {2'd3, 1'b1, 3'd1}) begin n_bad++; $display("FAIL loss_sticky: got st=%0d lost=%b cnt=%0d want 3 1 1", st1, lost1, cnt1); end
        clr = 1;
        step1(e1);
        clr = 0;
        n_cmp++; if ({st1, lost1, cnt1} !== {2'd0, 1'b0, 3'd0}) begin n_bad++; $display("FAIL loss_clr: got st=%0d lost=%b cnt=%0d want 0 0 0", st1, lost1, cnt1); end
    endtask

    task automatic test_saturate_wrap();
        do_reset();
        sat_mode = 1;
        step1(~e1);
        n_cmp++; if ({st1, cnt1} !== {2'd0, 3'd0}) begin n_bad++; $display("FAIL sat_miss: got st=%0d cnt=%0d want 0 0", st1, cnt1); end
        for (int k = 1; k <= 7; k++) begin
            step1(e1);
            if (k == 5) begin
                n_cmp++; if ({hh1, hl1, st1} !== {1'b0, 1'b1, 2'd2}) begin n_bad++; $display("FAIL sat_hitlo: got hh=%b hl=%b st=%0d want 0 1 2", hh1, hl1, st1); end
            end
        end
        n_cmp++; if ({st1, cnt1} !== {2'd2, 3'd7}) begin n_bad++; $display("FAIL sat_max: got st=%0d cnt=%0d want 2 7", st1, cnt1); end
        step1(e1);
        n_cmp++; if (cnt1 !== 3'd7) begin n_bad++; $display("FAIL sat_hold: got %0d want 7", cnt1); end
        sat_mode = 0;
        step1(e1);
        n_cmp++; if ({st1, cnt1} !== {2'd2, 3'd0}) begin n_bad++; $display("FAIL wrap_zero: got st=%0d cnt=%0d want 2 0", st1, cnt1); end
        step1(e1);
        n_cmp++; if ({st1, cnt1} !== {2'd2, 3'd1}) begin n_bad++; $display("FAIL wrap_next: got st=%0d cnt=%0d want 2 1", st1, cnt1); end
    endtask

    task automatic test_enable_hold();
        do_reset();
        repeat (3) step1(e1);
        en = 0;
        for (int k = 0; k < 3; k++) begin
            step1(e1);
            n_cmp++; if ({cnt1, st1, ec1} !== {3'd3, 2'd1, 1'b0}) begin n_bad++; $display("FAIL hold%0d: got cnt=%0d st=%0d echo=%b want 3 1 0", k, cnt1, st1, ec1); end
        end
        en = 1;
        step1(e1);
        n_cmp++; if (cnt1 !== 3'd4) begin n_bad++; $display("FAIL hold_resume: got %0d want 4", cnt1); end
    endtask

    task automatic test_period3();
        do_reset();
        n_cmp++; if (z4 !== 1'b1) begin n_bad++; $display("FAIL p3_zidle_rst: got %b want 1", z4); end
        i4 = 4'h1; #1;
        n_cmp++; if (z4 !== 1'b0) begin n_bad++; $display("FAIL p3_zidle_inz: got %b want 0", z4); end
        for (int k = 1; k <= 5; k++) begin
            step4(e4);
            n_cmp++; if ({cnt4, st4} !== {3'(k), k < 5 ? 2'd1 : 2'd2}) begin n_bad++; $display("FAIL p3_run%0d: got cnt=%0d st=%0d want %0d %0d", k, cnt4, st4, k, k < 5 ? 1 : 2); end
            if (k == 1) begin
                n_cmp++; if (ec4 !== 1'b1) begin n_bad++; $display("FAIL p3_echo: got %b want 1", ec4); end
            end
            i4 = 4'h0; #1;
            n_cmp++; if (z4 !== (e4 == 4'h0 && d4 == 4'h0)) begin n_bad++; $display("FAIL p3_zidle%0d: got %b want %b", k, z4, e4 == 4'h0 && d4 == 4'h0); end
        end
        n_cmp++; if (e4 !== 4'hF || hh4 !== 1'b1) begin n_bad++; $display("FAIL p3_hithi: got %b want 1", hh4); end
        step4(e4);
        step4(e4);
        n_cmp++; if ({e4, d4, z4} !== {4'h0, 4'h0, 1'b1}) begin n_bad++; $display("FAIL p3_zidle_back: got %b want 1", z4); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        repeat (6) step1(e1);
        n_cmp++; if ({st1, cnt1} !== {2'd2, 3'd6}) begin n_bad++; $display("FAIL rp_pre: got st=%0d cnt=%0d want 2 6", st1, cnt1); end
        rst_n = 0; i1 = 0;
        @(posedge clk); #1;
        e1 = 0;
        n_cmp++; if ({cnt1, st1, lost1, hh1, hl1, ec1, z1} !== {3'd0, 2'd0, 5'b00001}) begin n_bad++; $display("FAIL rp_reset: got cnt=%0d st=%0d flags=%b want 0 0 00001", cnt1, st1, {lost1, hh1, hl1, ec1, z1}); end
        rst_n = 1;
        step1(e1);
        step1(e1);
        n_cmp++; if (cnt1 !== 3'd2) begin n_bad++; $display("FAIL rp_restart: got %0d want 2", cnt1); end
        rst_n = 0; clr = 1;
        i1 = e1;
        @(posedge clk); #1;
        e1 = 0; rst_n = 1; clr = 0; i1 = 0; #1;
        n_cmp++; if ({cnt1, st1, z1} !== {3'd0, 2'd0, 1'b1}) begin n_bad++; $display("FAIL rp_both: got cnt=%0d st=%0d z=%b want 0 0 1", cnt1, st1, z1); end
    endtask

    initial begin
        clk = 0; rst_n = 0; en = 1; clr = 0; sat_mode = 0; i1 = 0; i4 = 0;
        n_cmp = 0; n_bad = 0;
        test_reset();
        test_lock();
        test_loss();
        test_saturate_wrap();
        test_enable_hold();
        test_period3();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
